// File: rtl/stages_definition_pkg.sv
// stages_definition_pkg: shared pipeline-stage types (memory-stage states, mem->wb bundle) and defaults
package stages_definition_pkg;
  localparam int XLEN = 32;
  localparam int MEM_TIMEOUT_DEFAULT = 64;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
  typedef struct packed {
    logic            wb_regWrite;
    logic [3:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
  } mem_wb_interface;
endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts enabled cycles; expired_o while enabled at TIMEOUT-1 (in clk_i rst_ni en_i clr_i, out expired_o)
module mem_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: pipeline memory stage; ex->mem bundle in, data-memory req/ack, mem->wb bundle, stall and sticky err out
module mem_stage_ctrl import stages_definition_pkg::*; #(
  parameter int N       = XLEN,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic              memRead_i,
  input  logic              memWrite_i,
  input  logic              regWrite_i,
  input  logic [3:0]        rd_i,
  input  logic [N-1:0]      aluResult_i,
  input  logic [N-1:0]      WD_i,
  output logic              stall_o,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [N-1:0]      dm_wdata_o,
  input  logic              dm_ack_i,
  input  logic [N-1:0]      dm_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_regWrite_o,
  output logic [3:0]        wb_rd_o,
  output logic [N-1:0]      wb_data_o,
  output logic [N-1:0]      forwardFromMem_o,
  output logic              err_o
);
  mem_state_t state_q, state_d;
  mem_wb_interface wb_q, wb_d;
  logic wb_valid_q, wb_valid_d, err_q, err_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [3:0] prd_q, prd_d;
  logic prw_q, prw_d, pld_q, pld_d;
  logic in_access, accept, mem_op, illegal, expired;
  assign in_access = state_q == ACCESS;
  assign accept    = in_valid_i && !in_access;
  assign mem_op    = memRead_i || memWrite_i;
  assign illegal   = (memRead_i && memWrite_i) || (aluResult_i[1:0] != 2'b00);
  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i,
    .rst_ni,
    .en_i      (in_access),
    .clr_i     (!in_access || dm_ack_i || expired),
    .expired_o (expired)
  );
  always_comb begin
    state_d    = state_q;
    wb_d       = wb_q;
    wb_valid_d = 1'b0;
    err_d      = err_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    prd_d      = prd_q;
    prw_d      = prw_q;
    pld_d      = pld_q;
    if (in_access) begin
      if (dm_ack_i || expired) begin
        state_d          = DONE;
        wb_valid_d       = 1'b1;
        wb_d.wb_rd       = prd_q;
        wb_d.wb_regWrite = dm_ack_i && pld_q && prw_q;
        wb_d.wb_data     = (dm_ack_i && pld_q) ? dm_rdata_i : '0;
        err_d            = err_q || !dm_ack_i;
      end
    end else begin
      state_d = IDLE;
      if (accept && mem_op && !illegal) begin
        state_d = ACCESS;
        we_d    = memWrite_i;
        addr_d  = aluResult_i[ADDR_W+1:2];
        wdata_d = WD_i;
        prd_d   = rd_i;
        prw_d   = regWrite_i;
        pld_d   = memRead_i;
      end else if (accept) begin
        // illegal memory requests retire as a bubble carrying no data
        wb_valid_d       = 1'b1;
        wb_d.wb_rd       = rd_i;
        wb_d.wb_regWrite = regWrite_i && !mem_op;
        wb_d.wb_data     = mem_op ? '0 : aluResult_i;
        err_d            = err_q || mem_op;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      prd_q      <= '0;
      prw_q      <= 1'b0;
      pld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      prd_q      <= prd_d;
      prw_q      <= prw_d;
      pld_q      <= pld_d;
    end
  end
  // stall and dm_req come straight from the state so reset drops them without a clock
  assign stall_o          = in_access;
  assign dm_req_o         = in_access;
  assign dm_we_o          = we_q;
  assign dm_addr_o        = addr_q;
  assign dm_wdata_o       = wdata_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_regWrite_o    = wb_q.wb_regWrite;
  assign wb_rd_o          = wb_q.wb_rd;
  assign wb_data_o        = wb_q.wb_data;
  assign forwardFromMem_o = wb_q.wb_data;
  assign err_o            = err_q;
endmodule
